// File: rtl/door_game_pkg.sv
// Shared types and constants for the door-guessing game controller.
package door_game_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StReveal,
    StGameOver
  } game_state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [1:0] dec_sat(input logic [1:0] v);
    return (v == 2'd0) ? 2'd0 : v - 2'd1;
  endfunction

endpackage

// File: rtl/door_game_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; seeded non-zero so it never locks up.
module lfsr8
  import door_game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/door_game_ctrl.sv
// Round sequencing, timing, lock capture, scoring and winner decision for the door game.
module door_game_ctrl
  import door_game_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 25_000_000,
  parameter int unsigned ROUND_SECONDS  = 10,
  parameter int unsigned REVEAL_SECONDS = 3,
  parameter int unsigned LIVES          = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] p1_choice,
  input  logic [1:0] p2_choice,
  input  logic       p1_lock,
  input  logic       p2_lock,
  output logic [1:0] correct_door,
  output logic [1:0] p1_lives,
  output logic [1:0] p2_lives,
  output logic       time_up,
  output logic [3:0] seconds_left,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

  game_state_t state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] secs_q, secs_d, seconds_left_q, seconds_left_d;
  logic p1_locked_q, p1_locked_d, p2_locked_q, p2_locked_d;
  logic [1:0] p1_pick_q, p1_pick_d, p2_pick_q, p2_pick_d;
  logic [1:0] correct_door_q, correct_door_d, winner_q, winner_d;
  logic [1:0] p1_lives_q, p1_lives_d, p2_lives_q, p2_lives_d;
  logic time_up_q, time_up_d, game_over_q, game_over_d;

  logic [7:0] lfsr;
  logic lfsr_unused;
  logic wrap, enter_round, p1_has, p2_has;
  logic [1:0] p1_sel, p2_sel;

  lfsr8 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .q    (lfsr)
  );

  assign lfsr_unused = ^lfsr[7:2];

  always_comb begin
    state_d        = state_q;
    pre_d          = pre_q;
    secs_d         = secs_q;
    p1_locked_d    = p1_locked_q;
    p2_locked_d    = p2_locked_q;
    p1_pick_d      = p1_pick_q;
    p2_pick_d      = p2_pick_q;
    correct_door_d = correct_door_q;
    p1_lives_d     = p1_lives_q;
    p2_lives_d     = p2_lives_q;
    time_up_d      = time_up_q;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    enter_round    = 1'b0;

    wrap   = (pre_q == PRE_MAX);
    // A lock arriving on the exit cycle still counts toward scoring.
    p1_has = p1_locked_q | p1_lock;
    p2_has = p2_locked_q | p2_lock;
    p1_sel = p1_locked_q ? p1_pick_q : p1_choice;
    p2_sel = p2_locked_q ? p2_pick_q : p2_choice;

    unique case (state_q)
      StIdle: begin
        if (start) enter_round = 1'b1;
      end
      StRound: begin
        if (p1_lock && !p1_locked_q) begin
          p1_locked_d = 1'b1;
          p1_pick_d   = p1_choice;
        end
        if (p2_lock && !p2_locked_q) begin
          p2_locked_d = 1'b1;
          p2_pick_d   = p2_choice;
        end
        pre_d = wrap ? '0 : pre_q + PW'(1);
        if (wrap && secs_q != 4'd0) secs_d = secs_q - 4'd1;
        if ((p1_has && p2_has) || (wrap && secs_q == 4'd1)) begin
          state_d   = StReveal;
          time_up_d = 1'b1;
          pre_d     = '0;
          secs_d    = 4'(REVEAL_SECONDS);
          if (!(p1_has && p1_sel == correct_door_q)) p1_lives_d = dec_sat(p1_lives_q);
          if (!(p2_has && p2_sel == correct_door_q)) p2_lives_d = dec_sat(p2_lives_q);
        end
      end
      StReveal: begin
        pre_d = wrap ? '0 : pre_q + PW'(1);
        if (wrap) begin
          if (secs_q <= 4'd1) begin
            if (p1_lives_q == 2'd0 || p2_lives_q == 2'd0) begin
              state_d     = StGameOver;
              time_up_d   = 1'b0;
              game_over_d = 1'b1;
              if (p1_lives_q == 2'd0 && p2_lives_q == 2'd0) winner_d = WIN_DRAW;
              else if (p1_lives_q == 2'd0)                  winner_d = WIN_P2;
              else                                          winner_d = WIN_P1;
            end else begin
              enter_round = 1'b1;
            end
          end else begin
            secs_d = secs_q - 4'd1;
          end
        end
      end
      StGameOver: begin
        if (start) begin
          p1_lives_d  = 2'(LIVES);
          p2_lives_d  = 2'(LIVES);
          winner_d    = WIN_NONE;
          game_over_d = 1'b0;
          enter_round = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_round) begin
      state_d        = StRound;
      correct_door_d = lfsr[1:0];
      p1_locked_d    = 1'b0;
      p2_locked_d    = 1'b0;
      pre_d          = '0;
      secs_d         = 4'(ROUND_SECONDS);
      time_up_d      = 1'b0;
    end

    seconds_left_d = (state_d == StRound) ? secs_d : 4'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      pre_q          <= '0;
      secs_q         <= 4'd0;
      seconds_left_q <= 4'd0;
      p1_locked_q    <= 1'b0;
      p2_locked_q    <= 1'b0;
      p1_pick_q      <= 2'd0;
      p2_pick_q      <= 2'd0;
      correct_door_q <= 2'd0;
      p1_lives_q     <= 2'(LIVES);
      p2_lives_q     <= 2'(LIVES);
      time_up_q      <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= WIN_NONE;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      secs_q         <= secs_d;
      seconds_left_q <= seconds_left_d;
      p1_locked_q    <= p1_locked_d;
      p2_locked_q    <= p2_locked_d;
      p1_pick_q      <= p1_pick_d;
      p2_pick_q      <= p2_pick_d;
      correct_door_q <= correct_door_d;
      p1_lives_q     <= p1_lives_d;
      p2_lives_q     <= p2_lives_d;
      time_up_q      <= time_up_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  assign correct_door = correct_door_q;
  assign p1_lives     = p1_lives_q;
  assign p2_lives     = p2_lives_q;
  assign time_up      = time_up_q;
  assign seconds_left = seconds_left_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_door_game_ctrl.sv
// Self-checking bench for door_game_ctrl: table of rounds plus hand-written reset/start sequences.
module tb_door_game_ctrl;

  localparam int unsigned CLK_HZ = 4;
  localparam int unsigned RS     = 3;
  localparam int unsigned VS     = 2;
  localparam int unsigned LV     = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_lock = 1'b0, p2_lock = 1'b0;
  logic [1:0] p1_choice = 2'd0, p2_choice = 2'd0;
  logic [1:0] correct_door, p1_lives, p2_lives, winner;
  logic       time_up, game_over;
  logic [3:0] seconds_left;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_lfsr, m_prev;

  typedef struct {
    int         p1_cyc;
    bit         p1_ok;
    int         p1_extra;
    int         p2_cyc;
    bit         p2_ok;
    logic [1:0] exp_p1;
    logic [1:0] exp_p2;
    bit         exp_go;
    logic [1:0] exp_win;
    bit         abort;
  } round_t;

  typedef struct {
    logic [1:0] p1;
    logic [1:0] p2;
    int         cyc;
  } exp_t;

  round_t rounds[10];
  exp_t   sb[$];

  door_game_ctrl #(
    .CLK_HZ        (CLK_HZ),
    .ROUND_SECONDS (RS),
    .REVEAL_SECONDS(VS),
    .LIVES         (LV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .p1_choice   (p1_choice),
    .p2_choice   (p2_choice),
    .p1_lock     (p1_lock),
    .p2_lock     (p2_lock),
    .correct_door(correct_door),
    .p1_lives    (p1_lives),
    .p2_lives    (p2_lives),
    .time_up     (time_up),
    .seconds_left(seconds_left),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  // Reference LFSR; m_prev holds the value the DUT saw at the most recent edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_round(input round_t r);
    logic [1:0] door;
    int         rev;
    int         c;
    exp_t       e;
    door = m_prev[1:0];
    check("round_door", correct_door, door);
    check("round_entry_secs", seconds_left, RS);
    check("round_entry_time_up", time_up, 0);
    if (r.p1_cyc != 0 && r.p2_cyc != 0)
      rev = ((r.p1_cyc > r.p2_cyc) ? r.p1_cyc : r.p2_cyc) + 1;
    else
      rev = RS * CLK_HZ + 1;
    e.p1 = r.exp_p1;
    e.p2 = r.exp_p2;
    e.cyc = rev;
    sb.push_back(e);

    for (c = 1; c <= 30; c++) begin
      if (time_up === 1'b1) break;
      check("round_secs", seconds_left, RS - (c - 1) / CLK_HZ);
      p1_lock   = (c == r.p1_cyc) || (c == r.p1_extra);
      // The ignored second lock always names the prize door.
      p1_choice = (c == r.p1_cyc) ? (r.p1_ok ? door : door ^ 2'd1) : door;
      p2_lock   = (c == r.p2_cyc);
      p2_choice = r.p2_ok ? door : door ^ 2'd2;
      tick();
    end
    p1_lock = 1'b0;
    p2_lock = 1'b0;

    e = sb.pop_front();
    check("reveal_cycle", c, e.cyc);
    check("reveal_p1_lives", p1_lives, e.p1);
    check("reveal_p2_lives", p2_lives, e.p2);
    check("reveal_secs", seconds_left, 0);
    if (r.abort) return;

    for (c = 1; c <= 30; c++) begin
      tick();
      if (time_up !== 1'b1 || game_over === 1'b1) break;
    end
    check("reveal_len", c, VS * CLK_HZ);
    check("post_reveal_time_up", time_up, 0);
    check("post_reveal_game_over", game_over, r.exp_go);
    if (r.exp_go) check("winner", winner, r.exp_win);
  endtask

  initial begin
    logic [1:0] door_e;

    //            p1c ok ext p2c ok  p1L   p2L  go  win    abort
    rounds[0] = '{2, 1, 0, 5, 1, 2'd3, 2'd3, 0, 2'b00, 0};
    rounds[1] = '{0, 0, 0, 0, 0, 2'd2, 2'd2, 0, 2'b00, 0};
    rounds[2] = '{3, 1, 0, 3, 0, 2'd2, 2'd1, 0, 2'b00, 0};
    rounds[3] = '{1, 0, 2, 4, 1, 2'd1, 2'd1, 0, 2'b00, 0};
    rounds[4] = '{2, 0, 0, 2, 1, 2'd0, 2'd1, 1, 2'b10, 0};
    rounds[5] = '{2, 0, 0, 3, 0, 2'd2, 2'd2, 0, 2'b00, 0};
    rounds[6] = '{1, 0, 0, 0, 0, 2'd1, 2'd1, 0, 2'b00, 0};
    rounds[7] = '{0, 0, 0, 0, 0, 2'd0, 2'd0, 1, 2'b11, 0};
    rounds[8] = '{1, 1, 0, 1, 0, 2'd3, 2'd2, 0, 2'b00, 0};
    rounds[9] = '{1, 0, 0, 1, 0, 2'd2, 2'd1, 0, 2'b00, 1};

    #1 reset = 1'b0;
    #20;
    check("rst_door", correct_door, 0);
    check("rst_p1_lives", p1_lives, LV);
    check("rst_p2_lives", p2_lives, LV);
    check("rst_time_up", time_up, 0);
    check("rst_secs", seconds_left, 0);
    check("rst_game_over", game_over, 0);
    check("rst_winner", winner, 0);

    @(negedge clk) reset = 1'b1;
    tick();
    tick();
    check("idle_secs", seconds_left, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_p1_lives", p1_lives, LV);
    check("start_p2_lives", p2_lives, LV);

    for (int i = 0; i < 10; i++) begin
      run_round(rounds[i]);
      if (rounds[i].exp_go) begin
        tick();
        tick();
        check("go_held", game_over, 1);
        check("go_held_p1_lives", p1_lives, rounds[i].exp_p1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_p1_lives", p1_lives, LV);
        check("restart_p2_lives", p2_lives, LV);
        check("restart_winner", winner, 0);
        check("restart_game_over", game_over, 0);
      end
    end

    // Last round stopped at reveal entry with lives 2/1; reset mid-reveal.
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("midrst_p1_lives", p1_lives, LV);
    check("midrst_p2_lives", p2_lives, LV);
    check("midrst_time_up", time_up, 0);
    check("midrst_secs", seconds_left, 0);
    check("midrst_door", correct_door, 0);
    check("midrst_game_over", game_over, 0);

    @(negedge clk) reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    door_e = m_prev[1:0];
    check("rst_round_door", correct_door, door_e);
    check("rst_round_secs", seconds_left, RS);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("start_in_round_secs_c4", seconds_left, RS);
    tick();
    check("start_in_round_secs_c5", seconds_left, RS - 1);
    check("start_in_round_door", correct_door, door_e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
